// File: rtl/vga_scan_out_pkg.sv
// Shared types and default 640x480@60 timing for the VGA scan-out stage.
// Colour is 15-bit packed {b,g,r}; the flag bundle travels alongside each pixel.
package vga_pkg;

  localparam int CNT_W = 10;
  localparam int IMG_W = 512;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_H_BORDER = 64;
  localparam logic [14:0] DEF_BORDER_RGB = 15'h0000;

  typedef struct packed {
    logic [4:0] b;
    logic [4:0] g;
    logic [4:0] r;
  } rgb15_t;

  typedef enum logic {
    WAIT,
    RUN
  } scan_state_t;

  // Per-pixel control bits delayed in step with the colour path.
  typedef struct packed {
    logic de;
    logic win;
    logic hs;
    logic vs;
    logic first;
  } pix_flags_t;

  localparam pix_flags_t FLAGS_IDLE = '{de: 1'b0, win: 1'b0, hs: 1'b1, vs: 1'b1, first: 1'b0};

  function automatic rgb15_t dim_half(input rgb15_t p);
    rgb15_t q;
    q.b = {1'b0, p.b[4:1]};
    q.g = {1'b0, p.g[4:1]};
    q.r = {1'b0, p.r[4:1]};
    return q;
  endfunction

endpackage

// File: rtl/vga_scan_out_timing.sv
// VGA raster counters, sync/active decode and the WAIT/RUN start-up machine.
// Outputs are stage-0 (combinational from the counters); no backpressure.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_available,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             active,
  output logic             hs,
  output logic             vs
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_LO  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_HI  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_LO  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_HI  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  scan_state_t      state, state_nxt;
  logic             seen, seen_nxt;
  logic [CNT_W-1:0] hcnt_nxt, vcnt_nxt;
  logic             h_wrap;

  assign h_wrap = (hcnt == H_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= WAIT;
      seen  <= 1'b0;
      hcnt  <= '0;
      vcnt  <= V_LAST;
    end else begin
      state <= state_nxt;
      seen  <= seen_nxt;
      hcnt  <= hcnt_nxt;
      vcnt  <= vcnt_nxt;
    end
  end

  // 'seen' is the registered sample, so a request landing on the wrap cycle
  // itself only takes effect at the following wrap.
  always_comb begin
    state_nxt = state;
    seen_nxt  = seen;
    hcnt_nxt  = h_wrap ? '0 : hcnt + CNT_W'(1);
    vcnt_nxt  = vcnt;
    case (state)
      WAIT: begin
        if (frame_available) seen_nxt = 1'b1;
        if (h_wrap && seen) begin
          vcnt_nxt  = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (h_wrap) vcnt_nxt = (vcnt == V_LAST) ? '0 : vcnt + CNT_W'(1);
      end
      default: state_nxt = WAIT;
    endcase
  end

  assign active = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign hs     = !((hcnt >= HS_LO) && (hcnt < HS_HI));
  assign vs     = !((vcnt >= VS_LO) && (vcnt < VS_HI));

endmodule

// File: rtl/vga_scan_out.sv
// VGA scan-out: timing, line-buffer read address, border mux, registered pins; 3-cycle counter-to-pin latency, no backpressure.
// Optional 50% scanline dimming on odd lines is built only when VGA_SCANLINES_EN is defined.
module vga_scan_out
  import vga_pkg::*;
#(
  parameter int          H_ACTIVE   = DEF_H_ACTIVE,
  parameter int          H_FP       = DEF_H_FP,
  parameter int          H_SYNC     = DEF_H_SYNC,
  parameter int          H_BP       = DEF_H_BP,
  parameter int          V_ACTIVE   = DEF_V_ACTIVE,
  parameter int          V_FP       = DEF_V_FP,
  parameter int          V_SYNC     = DEF_V_SYNC,
  parameter int          V_BP       = DEF_V_BP,
  parameter int          H_BORDER   = DEF_H_BORDER,
  parameter logic [14:0] BORDER_RGB = DEF_BORDER_RGB
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_available,
  input  logic [14:0] outpixel,
  output logic [9:0]  read_x,
  output logic [4:0]  vga_r,
  output logic [4:0]  vga_g,
  output logic [4:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic        frame_start
);

  localparam logic [CNT_W-1:0] WIN_LO = CNT_W'(H_BORDER);
  localparam logic [CNT_W-1:0] WIN_HI = CNT_W'(H_BORDER + IMG_W);

  logic [CNT_W-1:0] hcnt, vcnt;
  logic             active, hs, vs;
  pix_flags_t       f0, f1, f2;
  logic [8:0]       img_x;
  rgb15_t           win_pix, pix_nxt, pix_q;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk             (clk),
    .reset_n         (reset_n),
    .frame_available (frame_available),
    .hcnt            (hcnt),
    .vcnt            (vcnt),
    .active          (active),
    .hs              (hs),
    .vs              (vs)
  );

  always_comb begin
    f0       = FLAGS_IDLE;
    f0.de    = active;
    f0.win   = active && (hcnt >= WIN_LO) && (hcnt < WIN_HI);
    f0.hs    = hs;
    f0.vs    = vs;
    f0.first = active && (hcnt == '0) && (vcnt == '0);
  end

  assign img_x = 9'(hcnt - WIN_LO);

  // vline selects the line-buffer half; address is left parked outside the window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_x <= '0;
      f1     <= FLAGS_IDLE;
      f2     <= FLAGS_IDLE;
    end else begin
      if (f0.win) read_x <= {vcnt[0], img_x};
      f1 <= f0;
      f2 <= f1;
    end
  end

`ifdef VGA_SCANLINES_EN
  logic odd1, odd2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      odd1 <= 1'b0;
      odd2 <= 1'b0;
    end else begin
      odd1 <= vcnt[0];
      odd2 <= odd1;
    end
  end

  assign win_pix = odd2 ? dim_half(outpixel) : rgb15_t'(outpixel);
`else
  assign win_pix = rgb15_t'(outpixel);
`endif

  always_comb begin
    pix_nxt = '0;
    if (f2.win)     pix_nxt = win_pix;
    else if (f2.de) pix_nxt = rgb15_t'(BORDER_RGB);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_q       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_de      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_q       <= pix_nxt;
      vga_hs      <= f2.hs;
      vga_vs      <= f2.vs;
      vga_de      <= f2.de;
      frame_start <= f2.first;
    end
  end

  assign vga_r = pix_q.r;
  assign vga_g = pix_q.g;
  assign vga_b = pix_q.b;

endmodule

// File: tb/tb_vga_scan_out.sv
// Directed bench for vga_scan_out with a shortened vertical raster (15 lines) to keep runtime small.
// Expected pin values are queued per (line,pixel) and popped as the raster reaches them.
module tb_vga_scan_out;

  localparam int HT    = 800;
  localparam int VA    = 8;
  localparam int VFP   = 2;
  localparam int VSW   = 2;
  localparam int VBP   = 3;
  localparam int VT    = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam logic [14:0] BRD = 15'h1234;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_available = 1'b0;
  logic [14:0] outpixel = '0;
  logic [9:0]  read_x;
  logic [4:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_de, frame_start;

  int   n_assert = 0;
  int   n_fail = 0;
  int   k = 0;
  logic mode = 1'b0;

  typedef struct {
    int          line;
    int          pix;
    logic        de;
    logic [14:0] rgb;
    logic        chk_rx;
    logic [9:0]  rx;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  vga_scan_out #(
    .V_ACTIVE   (VA),
    .V_FP       (VFP),
    .V_SYNC     (VSW),
    .V_BP       (VBP),
    .BORDER_RGB (BRD)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .frame_available (frame_available),
    .outpixel        (outpixel),
    .read_x          (read_x),
    .vga_r           (vga_r),
    .vga_g           (vga_g),
    .vga_b           (vga_b),
    .vga_hs          (vga_hs),
    .vga_vs          (vga_vs),
    .vga_de          (vga_de),
    .frame_start     (frame_start)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release: interval k carries stage-0 hcnt = k % HT.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) k <= 0;
    else          k <= k + 1;
  end

  // Upscaler line-buffer model: one-cycle registered read.
  always @(posedge clk) begin
    outpixel <= mode ? 15'h7FFF : {read_x[4:0], read_x[4:0], read_x[4:0]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_read_x"}, read_x, 0);
    check({pfx, "_rgb"}, {vga_b, vga_g, vga_r}, 0);
    check({pfx, "_hs"}, vga_hs, 1);
    check({pfx, "_vs"}, vga_vs, 1);
    check({pfx, "_de"}, vga_de, 0);
    check({pfx, "_fs"}, frame_start, 0);
  endtask

  function automatic logic [14:0] win_exp(input int line, input logic [4:0] v);
    logic [4:0] c;
    c = v;
`ifdef VGA_SCANLINES_EN
    if (line % 2 == 1) c = v >> 1;
`endif
    return {c, c, c};
  endfunction

  task automatic push(input int line, input int pix, input logic de, input logic [14:0] rgb,
                      input logic chk_rx, input logic [9:0] rx, input string tag);
    exp_t e;
    e.line = line; e.pix = pix; e.de = de; e.rgb = rgb;
    e.chk_rx = chk_rx; e.rx = rx; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Entered at the negedge where line 0 pixel 0 is on the pins; leaves one frame later.
  task automatic scan_frame(input bit rand_fa);
    int de_tot = 0, bad_lines = 0, line_de = 0;
    int vs_lo = 0, vs_first = -1, hs_lo = 0, hs_first = -1, fs_cnt = 0;
    for (int p = 0; p < FRAME; p++) begin
      int line, pix;
      line = p / HT;
      pix  = p % HT;
      if (rand_fa) frame_available = 1'($urandom_range(0, 1));
      if (vga_de) begin de_tot++; line_de++; end
      if (!vga_vs) begin vs_lo++; if (vs_first < 0) vs_first = p; end
      if (!vga_hs) begin hs_lo++; if (hs_first < 0) hs_first = p; end
      if (frame_start) fs_cnt++;
      if (pix == HT - 1) begin
        if (line_de != ((line < VA) ? 640 : 0)) bad_lines++;
        line_de = 0;
      end
      while (exp_q.size() > 0 && exp_q[0].line == line && exp_q[0].pix == pix) begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.tag, "_de"}, vga_de, e.de);
        check({e.tag, "_rgb"}, {vga_b, vga_g, vga_r}, e.rgb);
        if (e.chk_rx) check({e.tag, "_rx"}, read_x, e.rx);
      end
      @(negedge clk);
    end
    frame_available = 1'b0;
    check("de_total", de_tot, 640 * VA);
    check("de_bad_lines", bad_lines, 0);
    check("vs_low_cycles", vs_lo, VSW * HT);
    check("vs_first_low", vs_first, (VA + VFP) * HT);
    check("hs_low_cycles", hs_lo, 96 * VT);
    check("hs_first_low", hs_first, 656);
    check("fs_per_frame", fs_cnt, 1);
    check("sb_drained", exp_q.size(), 0);
    check("frame_period", frame_start, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    frame_available = 1'b0;
    mode = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    reset_n = 1'b1;

    // WAIT with no frame: vertical blanking, free-running hsync.
    begin
      int vs_bad = 0, de_bad = 0, hs_lo = 0, f1 = -1, f2 = -1;
      logic hs_prev = 1'b1;
      for (int i = 0; i < 2000; i++) begin
        if (vga_vs !== 1'b1) vs_bad++;
        if (vga_de !== 1'b0 || frame_start !== 1'b0) de_bad++;
        if (!vga_hs) hs_lo++;
        if (hs_prev && !vga_hs) begin
          if (f1 < 0) f1 = k;
          else if (f2 < 0) f2 = k;
        end
        hs_prev = vga_hs;
        @(negedge clk);
      end
      check("wait_vs_high", vs_bad, 0);
      check("wait_de_low", de_bad, 0);
      check("wait_hs_low_cycles", hs_lo, 192);
      check("wait_hs_fall1", f1, 659);
      check("wait_hs_fall2", f2, 1459);
    end

    // Request lands on the wrap cycle: start slips to the following wrap.
    while (k != 2399) @(negedge clk);
    frame_available = 1'b1;
    @(negedge clk);
    frame_available = 1'b0;

    push(0,   0, 1, BRD,               0, 0,      "f1_l0_p0");
    push(0,  63, 1, BRD,               0, 0,      "f1_l0_p63");
    push(0,  64, 1, win_exp(0, 0),     1, 10'h002, "f1_l0_p64");
    push(0, 100, 1, win_exp(0, 4),     1, 10'h026, "f1_l0_p100");
    push(0, 639, 1, BRD,               0, 0,      "f1_l0_p639");
    push(0, 640, 0, 0,                 0, 0,      "f1_l0_p640");
    push(1,  63, 1, BRD,               0, 0,      "f1_l1_p63");
    push(1,  64, 1, win_exp(1, 0),     1, 10'h202, "f1_l1_p64");
    push(1, 100, 1, win_exp(1, 4),     1, 10'h226, "f1_l1_p100");
    push(1, 575, 1, win_exp(1, 31),    0, 0,      "f1_l1_p575");
    push(1, 576, 1, BRD,               0, 0,      "f1_l1_p576");
    push(1, 600, 1, BRD,               1, 10'h3FF, "f1_l1_p600");
    push(7, 639, 1, BRD,               0, 0,      "f1_l7_p639");
    push(8, 100, 0, 0,                 0, 0,      "f1_l8_vblank");

    for (int i = 0; i < 3000 && !frame_start; i++) @(negedge clk);
    check("fs_boundary_time", k, 3203);
    scan_frame(1'b0);

    // Second frame: flat white source, frame_available toggling randomly.
    mode = 1'b1;
    push(0,  63, 1, BRD,            0, 0, "f2_l0_p63");
    push(0,  64, 1, win_exp(0, 31), 0, 0, "f2_l0_p64");
    push(0, 300, 1, win_exp(0, 31), 0, 0, "f2_l0_p300");
    push(1,  64, 1, win_exp(1, 31), 0, 0, "f2_l1_p64");
    push(1, 575, 1, win_exp(1, 31), 0, 0, "f2_l1_p575");
    push(1, 576, 1, BRD,            0, 0, "f2_l1_p576");
    push(2, 200, 1, win_exp(2, 31), 0, 0, "f2_l2_p200");
    push(3, 640, 0, 0,              0, 0, "f2_l3_p640");
    scan_frame(1'b1);
    mode = 1'b0;

    // One-cycle reset mid-frame.
    repeat (3 * HT + 300) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge clk);
    reset_n = 1'b1;

    begin
      int vs_bad = 0, de_bad = 0;
      for (int i = 0; i < 900; i++) begin
        if (vga_vs !== 1'b1) vs_bad++;
        if (vga_de !== 1'b0 || frame_start !== 1'b0) de_bad++;
        @(negedge clk);
      end
      check("rewait_vs_high", vs_bad, 0);
      check("rewait_de_low", de_bad, 0);
    end

    // Ordinary request mid-line: start on the next wrap.
    while (k != 1000) @(negedge clk);
    frame_available = 1'b1;
    @(negedge clk);
    frame_available = 1'b0;

    push(0,  64, 1, win_exp(0, 0), 1, 10'h002, "f3_l0_p64");
    push(5, 100, 1, win_exp(5, 4), 0, 0,       "f3_l5_p100");
    push(6,  10, 1, BRD,           0, 0,       "f3_l6_p10");

    for (int i = 0; i < 3000 && !frame_start; i++) @(negedge clk);
    check("fs_normal_time", k, 1603);
    scan_frame(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
